// File: rtl/hash_collector_if.sv
// Port bundle between the blake2 byte-stream source and hash_collector.
// master drives the stream and read address; slave is the collector.
interface hash_collector_if #(
    parameter int CNT_W = 16
);
    logic             hash_v_i;
    logic [7:0]       hash_i;
    logic             clr_i;
    logic [5:0]       rd_addr_i;
    logic [7:0]       rd_data_o;
    logic             done_o;
    logic             err_o;
    logic [1:0]       err_code_o;
    logic [7:0]       sig_o;
    logic [CNT_W-1:0] frame_cnt_o;

    modport master (
        output hash_v_i, hash_i, clr_i, rd_addr_i,
        input  rd_data_o, done_o, err_o, err_code_o, sig_o, frame_cnt_o
    );

    modport slave (
        input  hash_v_i, hash_i, clr_i, rd_addr_i,
        output rd_data_o, done_o, err_o, err_code_o, sig_o, frame_cnt_o
    );
endinterface

// File: rtl/hash_collector.sv
// Captures byte-serial hash frames into a local buffer, checks frame length,
// keeps a good-frame count and XOR signature, and offers registered read-back.
module hash_collector #(
    parameter int HASH_BYTES = 32,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    hash_collector_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_CAPTURE = 2'b01,
        ST_DONE    = 2'b10,
        ST_ERROR   = 2'b11
    } state_t;

    localparam int               BUF_DEPTH = 64;
    localparam logic [6:0]       LAST_IDX  = 7'(HASH_BYTES - 1);
    localparam logic [6:0]       NUM_BYTES = 7'(HASH_BYTES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1'b1);

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_SHORT = 2'b01;
    localparam logic [1:0] ERR_OVER  = 2'b10;
    localparam logic [1:0] ERR_MID   = 2'b11;

    state_t           state_r;
    logic             hash_v_q_r;
    logic             armed_r;
    logic [6:0]       cnt_r;
    logic [7:0]       acc_r;
    logic [7:0]       sig_r;
    logic [CNT_W-1:0] frame_cnt_r;
    logic             done_r;
    logic             err_r;
    logic [1:0]       err_code_r;
    logic [7:0]       rd_data_r;
    logic [7:0]       buf_r [0:BUF_DEPTH-1];

    logic             rise_s;
    logic             wr_en_s;
    logic [5:0]       wr_idx_s;

    // Rising-edge qualification and buffer write decode.
    // armed_r stays low until valid is seen low once, so a frame already in
    // flight at reset release never looks like a fresh start.
    always_comb begin
        rise_s   = bus.hash_v_i & ~hash_v_q_r & armed_r;
        wr_en_s  = 1'b0;
        wr_idx_s = 6'd0;
        if (bus.clr_i) begin
            wr_en_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    wr_en_s = rise_s;
                end
                ST_CAPTURE: begin
                    wr_en_s  = bus.hash_v_i;
                    wr_idx_s = cnt_r[5:0];
                end
                default: begin
                    wr_en_s = 1'b0;
                end
            endcase
        end
    end

    // Byte buffer: plain storage, deliberately without reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            buf_r[wr_idx_s] <= bus.hash_i;
        end
    end

    // Registered read-back; out-of-frame addresses read as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_r <= 8'h00;
        end else if ({1'b0, bus.rd_addr_i} < NUM_BYTES) begin
            rd_data_r <= buf_r[bus.rd_addr_i];
        end else begin
            rd_data_r <= 8'h00;
        end
    end

    // Frame FSM with registered status outputs; clr_i overrides everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            hash_v_q_r  <= 1'b0;
            armed_r     <= 1'b0;
            cnt_r       <= 7'd0;
            acc_r       <= 8'h00;
            sig_r       <= 8'h00;
            frame_cnt_r <= '0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            err_code_r  <= ERR_NONE;
        end else begin
            hash_v_q_r <= bus.hash_v_i;
            if (!bus.hash_v_i) begin
                armed_r <= 1'b1;
            end

            if (bus.clr_i) begin
                state_r    <= ST_IDLE;
                cnt_r      <= 7'd0;
                done_r     <= 1'b0;
                err_r      <= 1'b0;
                err_code_r <= ERR_NONE;
            end else if (rise_s && (state_r == ST_IDLE || state_r == ST_DONE)) begin
                acc_r <= bus.hash_i;
                cnt_r <= 7'd1;
                if (HASH_BYTES == 1) begin
                    state_r     <= ST_DONE;
                    sig_r       <= bus.hash_i;
                    frame_cnt_r <= frame_cnt_r + CNT_ONE;
                    done_r      <= 1'b1;
                end else begin
                    state_r <= ST_CAPTURE;
                    done_r  <= 1'b0;
                end
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (bus.hash_v_i) begin
                            state_r    <= ST_ERROR;
                            err_r      <= 1'b1;
                            err_code_r <= ERR_MID;
                        end
                    end
                    ST_CAPTURE: begin
                        if (bus.hash_v_i) begin
                            acc_r <= acc_r ^ bus.hash_i;
                            cnt_r <= cnt_r + 7'd1;
                            if (cnt_r == LAST_IDX) begin
                                state_r     <= ST_DONE;
                                sig_r       <= acc_r ^ bus.hash_i;
                                frame_cnt_r <= frame_cnt_r + CNT_ONE;
                                done_r      <= 1'b1;
                            end
                        end else begin
                            state_r    <= ST_ERROR;
                            err_r      <= 1'b1;
                            err_code_r <= ERR_SHORT;
                        end
                    end
                    ST_DONE: begin
                        // Valid still high straight after the last byte is an overrun.
                        if (bus.hash_v_i && hash_v_q_r) begin
                            state_r    <= ST_ERROR;
                            done_r     <= 1'b0;
                            err_r      <= 1'b1;
                            err_code_r <= ERR_OVER;
                        end
                    end
                    ST_ERROR: begin
                        state_r <= ST_ERROR;
                    end
                    default: begin
                        state_r    <= ST_IDLE;
                        done_r     <= 1'b0;
                        err_r      <= 1'b0;
                        err_code_r <= ERR_NONE;
                    end
                endcase
            end
        end
    end

    assign bus.rd_data_o   = rd_data_r;
    assign bus.done_o      = done_r;
    assign bus.err_o       = err_r;
    assign bus.err_code_o  = err_code_r;
    assign bus.sig_o       = sig_r;
    assign bus.frame_cnt_o = frame_cnt_r;
endmodule

// File: tb/tb_hash_collector.sv
// Scoreboard bench for hash_collector: 32-byte instance plus a 1-byte variant.
module tb_hash_collector;
    logic clk;
    logic rst_n;

    hash_collector_if #(.CNT_W(16)) bus ();
    hash_collector_if #(.CNT_W(16)) bus1 ();

    hash_collector #(.HASH_BYTES(32), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    hash_collector #(.HASH_BYTES(1), .CNT_W(16)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    typedef struct {
        logic        done;
        logic        err;
        logic [1:0]  code;
        logic [7:0]  sig;
        logic [15:0] cnt;
        int          lat;
    } exp_t;

    exp_t        exp_q [$];
    logic [7:0]  rd_q  [$];
    logic [7:0]  frame_b [0:63];
    logic [7:0]  prev_b  [0:63];
    logic [15:0] m_cnt;
    logic [7:0]  m_sig;
    logic [7:0]  lfsr;
    int          n_vec;
    int          n_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] xor_frame(input int n);
        logic [7:0] x;
        x = 8'h00;
        for (int i = 0; i < n; i++) x = x ^ frame_b[i];
        return x;
    endfunction

    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return s[0] ? ((s >> 1) ^ 8'hB8) : (s >> 1);
    endfunction

    task automatic push_exp(input logic done, input logic err, input logic [1:0] code, input int lat);
        exp_t e;
        e.done = done; e.err = err; e.code = code;
        e.sig  = m_sig; e.cnt = m_cnt; e.lat = lat;
        exp_q.push_back(e);
    endtask

    // Wait (bounded) for a done/err event, then compare with the queued expectation.
    task automatic score(input string tag);
        exp_t e;
        int   lat;
        lat = 0;
        while (!(bus.done_o || bus.err_o) && lat < 40) begin
            tick();
            lat++;
        end
        if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s scoreboard empty", tag);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_lat"},  lat,            e.lat);
            check({tag, "_done"}, bus.done_o,     e.done);
            check({tag, "_err"},  bus.err_o,      e.err);
            check({tag, "_code"}, bus.err_code_o, e.code);
            check({tag, "_sig"},  bus.sig_o,      e.sig);
            check({tag, "_cnt"},  bus.frame_cnt_o, e.cnt);
        end
    endtask

    task automatic drive_bytes(input int first, input int n);
        for (int i = first; i < n; i++) begin
            bus.hash_v_i = 1'b1;
            bus.hash_i   = frame_b[i];
            tick();
        end
    endtask

    task automatic readback(input int n, input string tag);
        for (int a = 0; a < n; a++) begin
            rd_q.push_back(frame_b[a]);
            bus.rd_addr_i = 6'(a);
            tick();
            check(tag, bus.rd_data_o, rd_q.pop_front());
        end
    endtask

    task automatic clr_pulse();
        bus.clr_i = 1'b1;
        tick();
        bus.clr_i = 1'b0;
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        m_cnt = 16'd0; m_sig = 8'h00; lfsr = 8'h1D;
        rst_n = 1'b0;
        bus.hash_v_i = 1'b0; bus.hash_i = 8'h00; bus.clr_i = 1'b0; bus.rd_addr_i = 6'd0;
        bus1.hash_v_i = 1'b0; bus1.hash_i = 8'h00; bus1.clr_i = 1'b0; bus1.rd_addr_i = 6'd0;
        repeat (3) tick();
        check("rst_done", bus.done_o, 1'b0);
        check("rst_err",  bus.err_o, 1'b0);
        check("rst_code", bus.err_code_o, 2'b00);
        check("rst_sig",  bus.sig_o, 8'h00);
        check("rst_cnt",  bus.frame_cnt_o, 16'd0);
        check("rst_rd",   bus.rd_data_o, 8'h00);
        check("rst1_done", bus1.done_o, 1'b0);
        rst_n = 1'b1;
        tick();
        tick();

        // Good frame 0x00..0x1F
        for (int i = 0; i < 32; i++) frame_b[i] = 8'(i);
        m_cnt = m_cnt + 16'd1;
        m_sig = xor_frame(32);
        push_exp(1'b1, 1'b0, 2'b00, 0);
        drive_bytes(0, 32);
        bus.hash_v_i = 1'b0;
        score("good");
        readback(32, "good_rd");
        rd_q.push_back(8'h00);
        bus.rd_addr_i = 6'd40;
        tick();
        check("rd_oob", bus.rd_data_o, rd_q.pop_front());

        // Short frame of 20 x 0xA5
        for (int i = 0; i < 20; i++) frame_b[i] = 8'hA5;
        push_exp(1'b0, 1'b1, 2'b01, 1);
        drive_bytes(0, 20);
        bus.hash_v_i = 1'b0;
        score("short");
        clr_pulse();
        check("clr_err",  bus.err_o, 1'b0);
        check("clr_code", bus.err_code_o, 2'b00);
        check("clr_done", bus.done_o, 1'b0);
        check("clr_cnt",  bus.frame_cnt_o, m_cnt);

        // Overrun: 33 consecutive bytes
        for (int i = 0; i < 33; i++) frame_b[i] = 8'($urandom_range(0, 255));
        m_cnt = m_cnt + 16'd1;
        m_sig = xor_frame(32);
        push_exp(1'b1, 1'b0, 2'b00, 0);
        drive_bytes(0, 32);
        score("ovr_done");
        bus.hash_i = frame_b[32];
        tick();
        push_exp(1'b0, 1'b1, 2'b10, 0);
        score("ovr_err");
        bus.hash_v_i = 1'b0;
        clr_pulse();

        // Valid held high across reset release
        rst_n = 1'b0;
        bus.hash_v_i = 1'b1;
        bus.hash_i = 8'h3C;
        tick();
        tick();
        m_cnt = 16'd0;
        m_sig = 8'h00;
        check("mid_rst_cnt", bus.frame_cnt_o, m_cnt);
        rst_n = 1'b1;
        push_exp(1'b0, 1'b1, 2'b11, 1);
        score("mid");
        bus.hash_v_i = 1'b0;
        clr_pulse();
        for (int i = 0; i < 32; i++) frame_b[i] = 8'hFF;
        m_cnt = m_cnt + 16'd1;
        m_sig = xor_frame(32);
        push_exp(1'b1, 1'b0, 2'b00, 0);
        drive_bytes(0, 32);
        bus.hash_v_i = 1'b0;
        score("mid_good");

        // Three back-to-back LFSR frames, one idle cycle between
        tick();
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 64; i++) prev_b[i] = frame_b[i];
            for (int i = 0; i < 32; i++) begin
                lfsr = lfsr_next(lfsr);
                frame_b[i] = lfsr;
            end
            m_cnt = m_cnt + 16'd1;
            m_sig = xor_frame(32);
            push_exp(1'b1, 1'b0, 2'b00, 0);
            if (f == 2) begin
                bus.rd_addr_i = 6'd0;
                bus.hash_v_i  = 1'b1;
                bus.hash_i    = frame_b[0];
                tick();
                check("rw_old", bus.rd_data_o, prev_b[0]);
                drive_bytes(1, 32);
            end else begin
                drive_bytes(0, 32);
            end
            bus.hash_v_i = 1'b0;
            score("b2b");
            tick();
        end
        readback(32, "b2b_rd");

        // clr_i in the same cycle as a first byte
        bus.clr_i    = 1'b1;
        bus.hash_v_i = 1'b1;
        bus.hash_i   = 8'h77;
        tick();
        bus.clr_i  = 1'b0;
        bus.hash_i = 8'h78;
        check("prio_done", bus.done_o, 1'b0);
        check("prio_err",  bus.err_o, 1'b0);
        push_exp(1'b0, 1'b1, 2'b11, 1);
        score("prio");
        bus.hash_v_i = 1'b0;
        clr_pulse();
        readback(1, "prio_rd0");

        // Single-byte frame variant
        bus1.hash_v_i = 1'b1;
        bus1.hash_i   = 8'h5A;
        tick();
        check("hb1_done", bus1.done_o, 1'b1);
        check("hb1_err",  bus1.err_o, 1'b0);
        check("hb1_sig",  bus1.sig_o, 8'h5A);
        check("hb1_cnt",  bus1.frame_cnt_o, 16'd1);
        bus1.hash_v_i  = 1'b0;
        bus1.rd_addr_i = 6'd0;
        tick();
        check("hb1_hold", bus1.done_o, 1'b1);
        check("hb1_rd0",  bus1.rd_data_o, 8'h5A);
        bus1.rd_addr_i = 6'd1;
        tick();
        check("hb1_rd1",  bus1.rd_data_o, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/hash_collector.md
# hash_collector

Downstream consumer of the blake2 `top` output stream in the FPGA emulator. It captures each byte-serial hash frame from `uo_out` (qualified by `hash_v`, `uio_out[7]`) into a local byte buffer and checks the frame length. It also keeps a running frame count and an XOR signature for the debug LEDs, and offers a registered read-back port for on-board inspection.

## Interface
Parameters:
- `HASH_BYTES`, 32: expected bytes per frame; legal range 1–64.
- `CNT_W`, 16: width of the frame counter.

Ports:
- `clk` in 1: system clock, the PLL/BUFG clock that also drives `top`.
- `rst_n` in 1: reset. Asynchronous assert, active-low, one clock domain.
- `hash_v_i` in 1: byte valid (`uio_out[7]` of `top`).
- `hash_i` in 8: hash byte (`uo_out` of `top`).
- `clr_i` in 1: leave DONE/ERROR and re-arm; synchronous, single-cycle.
- `rd_addr_i` in 6: buffer read address.
- `rd_data_o` out 8: buffer byte at the registered address.
- `done_o` out 1: a complete frame of correct length is held.
- `err_o` out 1: a protocol error was detected.
- `err_code_o` out 2: 00 none, 01 short frame, 10 overrun, 11 mid-frame start.
- `sig_o` out 8: XOR of all bytes of the last captured frame.
- `frame_cnt_o` out CNT_W: number of good frames since reset.

## Operation
- `hash_v_q` registers `hash_v_i` and is used for rising-edge detection (`hash_v_i & ~hash_v_q`).
- IDLE:
  - A rising edge writes `buf[0]` and sets `cnt` to 1.
  - The running XOR `acc` is loaded with `hash_i`.
  - State goes to CAPTURE, or to DONE if `HASH_BYTES`==1.
  - `hash_v_i` high without a rising edge (asserted at reset release, or after `clr_i` mid-frame) gives ERROR with code 11.
- CAPTURE:
  - While `hash_v_i`=1: write `buf[cnt]`, update `acc ^= hash_i`, increment `cnt`.
  - When the write index equals `HASH_BYTES`-1: go to DONE, set `sig_o` = final `acc`, increment `frame_cnt_o`.
  - `hash_v_i`=0 with `cnt` < `HASH_BYTES` gives ERROR with code 01.
- DONE:
  - `hash_v_i` still high in the first cycle after the last byte gives ERROR with code 10. `done_o` drops, `frame_cnt_o` stays incremented, `buf` and `sig_o` are kept.
  - A new rising edge in DONE (after `hash_v` went low) starts a new capture as in IDLE, overwriting the buffer.
- ERROR:
  - Holds until `clr_i`. All inputs except `clr_i` are ignored.
  - `buf` contents are undefined past the last written index.
- `clr_i` has priority over every other event in every state:
  - Next state is IDLE and `err_code_o` is set to 0.
  - Any byte in the same cycle is discarded.
  - `sig_o` and `frame_cnt_o` are kept.
- `frame_cnt_o` wraps modulo 2^CNT_W.
- Read-back: `rd_data_o <= buf[rd_addr_i]` every cycle. Addresses ≥ `HASH_BYTES` return 0x00.
- `buf` is a plain register array with no reset; its contents are don't-care after reset.

## Timing
- Reset values: state IDLE, `done_o`=0, `err_o`=0, `err_code_o`=00, `sig_o`=0x00, `frame_cnt_o`=0, `rd_data_o`=0x00, `hash_v_q`=0, `cnt`=0.
- All outputs are registered. No combinational input-to-output path.
- Capture rate is one byte per cycle, with zero-cycle bubbles required inside a frame.
- `done_o`, `sig_o` and `frame_cnt_o` update in the cycle after the last byte is sampled (latency 1).
- `err_o` and `err_code_o` update in the cycle after the offending sample (latency 1). `err_o` equals (state==ERROR).
- Read-back latency is 1 cycle from `rd_addr_i` to `rd_data_o`.
- A write and a read of the same address in the same cycle return the old byte.
- Asserting reset mid-frame aborts immediately, with no partial `frame_cnt_o` increment. After release, a frame still in progress is reported as code 11.

## Test plan
- Good frame: 32 bytes 0x00..0x1F on consecutive cycles after reset → `done_o`=1 one cycle after byte 0x1F, `sig_o`=0x00, `frame_cnt_o`=1, reading addresses 0..31 returns 0x00..0x1F, reading address 40 returns 0x00.
- Short frame: 20 bytes of 0xA5, then `hash_v_i` low → `err_o`=1, `err_code_o`=01 one cycle after `hash_v` drops, `frame_cnt_o`=0; `clr_i` pulse → IDLE with `err_o`=0.
- Overrun: 33 consecutive valid bytes → `done_o` pulses for one cycle, then ERROR code 10; `frame_cnt_o`=1 and `sig_o` equals the XOR of the first 32 bytes.
- Mid-frame start: `hash_v_i` held high across reset release → ERROR code 11; after `clr_i` and a clean 32-byte frame of 0xFF → DONE, `sig_o`=0x00, `frame_cnt_o`=1.
- Back-to-back: three good frames separated by one idle cycle each, with bytes from an LFSR → `frame_cnt_o`=3, `sig_o` matches the reference XOR of frame 3, buffer holds frame 3.
- Priority: `clr_i` in the same cycle as the first byte of a frame → IDLE, byte dropped, the following bytes flag code 11; `HASH_BYTES`=1 variant: a single 0x5A byte → DONE next cycle with `sig_o`=0x5A.
